// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC sequencer, two-stage in-flight tag pipe matching the
// fixed 2-cycle instruction memory latency, and a credit-limited instruction buffer.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc
);

  localparam int unsigned      PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned      OCC_W     = $clog2(FIFO_DEPTH + 3);
  localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);

  logic [31:0]      pc_q, pc_d;
  logic             tag1_vld_q, tag1_vld_d;
  logic             tag2_vld_q, tag2_vld_d;
  logic [31:0]      tag1_pc_q, tag2_pc_q;
  logic [31:0]      fifo_instr_q [FIFO_DEPTH];
  logic [31:0]      fifo_pc_q    [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [OCC_W-1:0] count_q, count_d;
  logic [OCC_W-1:0] inflight;
  logic             issue;
  logic             push;
  logic             pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Credits count both buffered and in-flight words, so a returning word always has a slot.
  always_comb begin
    inflight = OCC_W'(tag1_vld_q) + OCC_W'(tag2_vld_q);
    issue    = !redirect_valid && ((count_q + inflight) < DEPTH_OCC);
    push     = tag2_vld_q && !redirect_valid;
    pop      = id_valid && id_ready && !redirect_valid;
  end

  always_comb begin
    pc_d       = pc_q;
    tag1_vld_d = issue;
    tag2_vld_d = tag1_vld_q && !redirect_valid;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    if (redirect_valid) begin
      pc_d     = redirect_pc & 32'hFFFF_FFFC;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (issue) pc_d = pc_q + 32'd4;
      if (push)  wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop)   rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      tag1_vld_q <= 1'b0;
      tag2_vld_q <= 1'b0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      pc_q       <= pc_d;
      tag1_vld_q <= tag1_vld_d;
      tag2_vld_q <= tag2_vld_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Tag stage 1 -> tag stage 2 -> buffer; payload only, qualified by the valid bits above.
  always_ff @(posedge clk) begin
    if (issue) tag1_pc_q <= pc_q;
    tag2_pc_q <= tag1_pc_q;
    if (push) begin
      fifo_instr_q[wr_ptr_q] <= imem_data;
      fifo_pc_q[wr_ptr_q]    <= tag2_pc_q;
    end
  end

  assert property (@(posedge clk) disable iff (rst) !(push && (count_q == DEPTH_OCC)));

  always_comb begin
    imem_addr = pc_q;
    id_valid  = (count_q != '0);
    id_instr  = id_valid ? fifo_instr_q[rd_ptr_q] : 32'd0;
    id_pc     = id_valid ? fifo_pc_q[rd_ptr_q]    : 32'd0;
  end

endmodule
